// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI responder.
package adc_spi_pkg;

  localparam int unsigned DEF_FRAME_BITS = 32;
  localparam logic        EOC_READY      = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EOC,
    ST_SHIFT,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection
// against a delayed copy of the synchronized level.
module spi_pin_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level_c,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level_c = sync_q[STAGES-1];
  assign rise_c  = level_c & ~dly_q;
  assign fall_c  = ~level_c & dly_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder for the delta-sigma ADC port: conversion timer, EOC-bar
// plus MSB-first data out on sdout, 32-bit config capture from sdin.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
  parameter int unsigned CONV_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic                  sdin,
  output logic                  sdout,
  output logic                  sdout_oe,
  input  logic [FRAME_BITS-3:0] sample_data,
  output logic                  sample_req,
  output logic [FRAME_BITS-1:0] cfg_word,
  output logic                  cfg_valid,
  output logic                  frame_abort,
  output logic                  data_ready
);

  localparam int unsigned DATA_BITS = FRAME_BITS - 2;
  localparam int unsigned CNT_W     = $clog2(CONV_CYCLES);
  localparam int unsigned BIT_W     = $clog2(FRAME_BITS + 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic sdin_s, sdin_rise, sdin_fall;
  logic sync_unused_c;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(sys_clk), .rst_n(sys_rst_n), .pin(cs),
    .level_c(cs_s), .rise_c(cs_rise), .fall_c(cs_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(sys_clk), .rst_n(sys_rst_n), .pin(sclk),
    .level_c(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdin_sync (
    .clk(sys_clk), .rst_n(sys_rst_n), .pin(sdin),
    .level_c(sdin_s), .rise_c(sdin_rise), .fall_c(sdin_fall));

  assign sync_unused_c = &{cs_s, sclk_s, sdin_rise, sdin_fall};

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      conv_cnt_q, conv_cnt_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  sdout_d, sdout_oe_d, sample_req_d, cfg_valid_d;
  logic                  frame_abort_d, data_ready_d;
  logic [FRAME_BITS-1:0] cfg_word_d;
  logic [FRAME_BITS-1:0] tx_load_c, rx_next_c;

  assign tx_load_c = data_ready ? {EOC_READY, 1'b0, hold_q} : '1;
  assign rx_next_c = {rx_q[FRAME_BITS-2:0], sdin_s};

  always_comb begin
    state_d       = state_q;
    conv_cnt_d    = conv_cnt_q;
    hold_d        = hold_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    bit_cnt_d     = bit_cnt_q;
    rd_valid_d    = rd_valid_q;
    sdout_d       = sdout;
    cfg_word_d    = cfg_word;
    cfg_valid_d   = 1'b0;
    frame_abort_d = 1'b0;
    sample_req_d  = 1'b0;
    data_ready_d  = data_ready;

    // Conversion timer: free-runs only while no unread result is held.
    if (!data_ready) begin
      if (conv_cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
        hold_d       = sample_data;
        sample_req_d = 1'b1;
        data_ready_d = 1'b1;
        conv_cnt_d   = '0;
      end else begin
        conv_cnt_d = conv_cnt_q + CNT_W'(1);
      end
    end

    if (state_q == ST_IDLE) begin
      sdout_d = 1'b1;
      if (cs_fall) begin
        tx_d       = tx_load_c;
        rd_valid_d = data_ready;
        sdout_d    = tx_load_c[FRAME_BITS-1];
        bit_cnt_d  = '0;
        state_d    = ST_EOC;
      end
    end else if (cs_rise) begin
      // cs rise has priority over any sclk edge seen in the same cycle.
      state_d = ST_IDLE;
      sdout_d = 1'b1;
      if (bit_cnt_q == BIT_W'(FRAME_BITS)) begin
        if (rd_valid_q) begin
          data_ready_d = 1'b0;
          conv_cnt_d   = '0;
        end
      end else if (bit_cnt_q != '0) begin
        frame_abort_d = 1'b1;
      end
    end else if (state_q != ST_DONE) begin
      if (sclk_rise) begin
        rx_d      = rx_next_c;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        state_d   = ST_SHIFT;
        if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
          cfg_word_d  = rx_next_c;
          cfg_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end else if (sclk_fall && state_q == ST_SHIFT) begin
        tx_d    = {tx_q[FRAME_BITS-2:0], 1'b1};
        sdout_d = tx_q[FRAME_BITS-2];
      end
    end

    sdout_oe_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      conv_cnt_q  <= '0;
      hold_q      <= '0;
      tx_q        <= '1;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      rd_valid_q  <= 1'b0;
      sdout       <= 1'b1;
      sdout_oe    <= 1'b0;
      sample_req  <= 1'b0;
      cfg_word    <= '0;
      cfg_valid   <= 1'b0;
      frame_abort <= 1'b0;
      data_ready  <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_cnt_q  <= conv_cnt_d;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      rd_valid_q  <= rd_valid_d;
      sdout       <= sdout_d;
      sdout_oe    <= sdout_oe_d;
      sample_req  <= sample_req_d;
      cfg_word    <= cfg_word_d;
      cfg_valid   <= cfg_valid_d;
      frame_abort <= frame_abort_d;
      data_ready  <= data_ready_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: bench-side SPI master with
// hand-computed expected words, pulse monitors and reset checks.
module tb_adc_spi_responder;

  localparam int unsigned HALF = 15;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        sdin = 1'b0;
  logic [29:0] sample_data = 30'h2AAAAAAA;
  logic        sdout, sdout_oe, sample_req, cfg_valid, frame_abort, data_ready;
  logic [31:0] cfg_word;

  adc_spi_responder #(.FRAME_BITS(32), .CONV_CYCLES(64), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cs(cs), .sclk(sclk), .sdin(sdin),
    .sdout(sdout), .sdout_oe(sdout_oe), .sample_data(sample_data),
    .sample_req(sample_req), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
    .frame_abort(frame_abort), .data_ready(data_ready));

  always #5 sys_clk = ~sys_clk;

  int total = 0, bad = 0;
  int cyc = 0, req_cnt = 0, req_cyc = 0, dr_fall_cyc = 0, valid_cnt = 0, abort_cnt = 0;
  logic dr_prev = 1'b0;

  // Pulse/edge monitor, sampled 1 time unit after the active edge.
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (sample_req) begin req_cnt++; req_cyc = cyc; end
    if (cfg_valid) valid_cnt++;
    if (frame_abort) abort_cnt++;
    if (dr_prev && !data_ready) dr_fall_cyc = cyc;
    dr_prev = data_ready;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_sdout"}, 32'(sdout), 32'd1);
    check_val({tag, "_oe"}, 32'(sdout_oe), 32'd0);
    check_val({tag, "_req"}, 32'(sample_req), 32'd0);
    check_val({tag, "_cfg"}, cfg_word, 32'd0);
    check_val({tag, "_valid"}, 32'(cfg_valid), 32'd0);
    check_val({tag, "_abort"}, 32'(frame_abort), 32'd0);
    check_val({tag, "_ready"}, 32'(data_ready), 32'd0);
  endtask

  task automatic wait_req(input int n);
    int k = 0;
    while (req_cnt < n && k < 500) begin
      @(negedge sys_clk);
      k++;
    end
    check_val("req_wait", 32'(req_cnt >= n), 32'd1);
  endtask

  task automatic spi_frame(input logic [31:0] mosi, input int nbits, input int rst_bit,
                           output logic [31:0] miso);
    miso = '0;
    cs = 1'b0;
    repeat (HALF) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        sys_rst_n = 1'b0;
        #2;
        check_reset_vals("s6_async");
        cs = 1'b1;
        sclk = 1'b0;
        sdin = 1'b0;
        return;
      end
      sdin = mosi[31-i];
      repeat (HALF) @(negedge sys_clk);
      sclk = 1'b1;
      miso[31-i] = sdout;
      repeat (HALF) @(negedge sys_clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge sys_clk);
    cs = 1'b1;
    repeat (20) @(negedge sys_clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    int c0, v0, a0, r0;

    repeat (3) @(negedge sys_clk);
    check_reset_vals("rst");

    // 1: first conversion; cs fall while not ready shows EOC-bar high.
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    c0 = cyc;
    repeat (5) @(negedge sys_clk);
    cs = 1'b0;
    repeat (10) @(negedge sys_clk);
    check_val("s1_sdout_busy", 32'(sdout), 32'd1);
    check_val("s1_oe_low_cs", 32'(sdout_oe), 32'd1);
    cs = 1'b1;
    repeat (10) @(negedge sys_clk);
    check_val("s1_oe_high_cs", 32'(sdout_oe), 32'd0);
    wait_req(1);
    check_val("s1_req_cycle", 32'(req_cyc - c0), 32'd64);
    check_val("s1_ready", 32'(data_ready), 32'd1);
    repeat (5) @(negedge sys_clk);
    check_val("s1_req_once", 32'(req_cnt), 32'd1);

    // 2: full read of a ready result with config capture.
    v0 = valid_cnt;
    spi_frame(32'hB0500000, 32, -1, rx);
    check_val("s2_rx", rx, 32'h2AAAAAAA);
    check_val("s2_cfg", cfg_word, 32'hB0500000);
    check_val("s2_valid_once", 32'(valid_cnt - v0), 32'd1);
    check_val("s2_ready_clr", 32'(data_ready), 32'd0);
    wait_req(2);
    check_val("s2_reconv", 32'(req_cyc - dr_fall_cyc), 32'd64);

    // 3: sclk toggling with cs high must be ignored.
    v0 = valid_cnt;
    a0 = abort_cnt;
    repeat (10) begin
      sclk = 1'b1;
      repeat (HALF) @(negedge sys_clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge sys_clk);
    end
    check_val("s3_valid", 32'(valid_cnt - v0), 32'd0);
    check_val("s3_abort", 32'(abort_cnt - a0), 32'd0);
    check_val("s3_ready", 32'(data_ready), 32'd1);
    check_val("s3_oe", 32'(sdout_oe), 32'd0);
    check_val("s3_sdout", 32'(sdout), 32'd1);

    // 4: abort after 12 rising edges, then a full re-read.
    a0 = abort_cnt;
    v0 = valid_cnt;
    spi_frame(32'hFFF00000, 12, -1, rx);
    check_val("s4_abort_once", 32'(abort_cnt - a0), 32'd1);
    check_val("s4_cfg_kept", cfg_word, 32'hB0500000);
    check_val("s4_valid_none", 32'(valid_cnt - v0), 32'd0);
    check_val("s4_ready_kept", 32'(data_ready), 32'd1);
    spi_frame(32'h12345678, 32, -1, rx);
    check_val("s4_reread", rx, 32'h2AAAAAAA);
    check_val("s4_cfg", cfg_word, 32'h12345678);
    check_val("s4_ready_clr", 32'(data_ready), 32'd0);

    // 5: frame while busy; conversion lands mid-frame.
    sample_data = 30'h01234567;
    r0 = req_cnt;
    spi_frame(32'hCAFE0001, 32, -1, rx);
    check_val("s5_rx_ones", rx, 32'hFFFFFFFF);
    check_val("s5_cfg", cfg_word, 32'hCAFE0001);
    check_val("s5_req_mid", 32'(req_cnt - r0), 32'd1);
    check_val("s5_ready", 32'(data_ready), 32'd1);
    spi_frame(32'h0F0F0F0F, 32, -1, rx);
    check_val("s5_new_sample", rx, 32'h01234567);
    check_val("s5_cfg2", cfg_word, 32'h0F0F0F0F);
    check_val("s5_ready_clr", 32'(data_ready), 32'd0);

    // 6: reset asserted at bit 20, then recovery.
    spi_frame(32'hDEADBEEF, 32, 20, rx);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    c0 = cyc;
    r0 = req_cnt;
    wait_req(r0 + 1);
    check_val("s6_req_cycle", 32'(req_cyc - c0), 32'd64);
    v0 = valid_cnt;
    spi_frame(32'hB0500000, 32, -1, rx);
    check_val("s6_rx", rx, 32'h01234567);
    check_val("s6_cfg", cfg_word, 32'hB0500000);
    check_val("s6_valid_once", 32'(valid_cnt - v0), 32'd1);
    check_val("s6_ready_clr", 32'(data_ready), 32'd0);
    wait_req(r0 + 2);
    check_val("s6_reconv", 32'(req_cyc - dr_fall_cyc), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
